// File: rtl/wb_bus_bridge_pkg.sv
// wb_bus_bridge_pkg: shared response codes and bridge FSM states
package wb_bus_bridge_pkg;
   localparam int RESP_OK = 0;
   typedef enum logic [2:0] {IDLE, R_ADDR, R_DATA, W_REQ, W_RESP, ACK} state_t;
endpackage

// File: rtl/wb_bus_bridge.sv
// wb_bus_bridge: Wishbone classic slave driving one copperv split valid/ready transaction per cycle
import wb_bus_bridge_pkg::*;
module wb_bus_bridge #(
   parameter int addr_width   = 32,
   parameter int data_width   = 32,
   parameter int strobe_width = data_width / 8,
   parameter int resp_width   = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [addr_width-1:0]   wb_adr,
   input  logic [data_width-1:0]   wb_datwr,
   output logic [data_width-1:0]   wb_datrd,
   input  logic                    wb_we,
   input  logic                    wb_stb,
   input  logic                    wb_cyc,
   input  logic [strobe_width-1:0] wb_sel,
   output logic                    wb_ack,
   output logic                    wb_err,
   output logic                    bus_r_addr_valid,
   input  logic                    bus_r_addr_ready,
   output logic [addr_width-1:0]   bus_r_addr,
   input  logic                    bus_r_data_valid,
   output logic                    bus_r_data_ready,
   input  logic [data_width-1:0]   bus_r_data,
   output logic                    bus_w_data_addr_valid,
   input  logic                    bus_w_data_addr_ready,
   output logic [data_width-1:0]   bus_w_data,
   output logic [addr_width-1:0]   bus_w_addr,
   output logic [strobe_width-1:0] bus_w_strobe,
   input  logic                    bus_w_resp_valid,
   output logic                    bus_w_resp_ready,
   input  logic [resp_width-1:0]   bus_w_resp
);
   state_t state;
   logic   abort;
   logic   abort_now;
   assign abort_now = abort | ~wb_cyc;
   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= IDLE;
         abort                 <= 1'b0;
         wb_datrd              <= '0;
         wb_ack                <= 1'b0;
         wb_err                <= 1'b0;
         bus_r_addr_valid      <= 1'b0;
         bus_r_addr            <= '0;
         bus_r_data_ready      <= 1'b0;
         bus_w_data_addr_valid <= 1'b0;
         bus_w_data            <= '0;
         bus_w_addr            <= '0;
         bus_w_strobe          <= '0;
         bus_w_resp_ready      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               abort <= 1'b0;
               if (wb_cyc && wb_stb) begin
                  if (wb_we) begin
                     bus_w_addr            <= wb_adr;
                     bus_w_data            <= wb_datwr;
                     bus_w_strobe          <= wb_sel;
                     bus_w_data_addr_valid <= 1'b1;
                     state                 <= W_REQ;
                  end else begin
                     bus_r_addr       <= wb_adr;
                     bus_r_addr_valid <= 1'b1;
                     state            <= R_ADDR;
                  end
               end
            end
            R_ADDR: begin
               abort <= abort_now;
               if (bus_r_addr_ready) begin
                  bus_r_addr_valid <= 1'b0;
                  bus_r_data_ready <= 1'b1;
                  state            <= R_DATA;
               end
            end
            R_DATA: begin
               abort <= abort_now;
               if (bus_r_data_valid) begin
                  bus_r_data_ready <= 1'b0;
                  // an abandoned read still drains the bus but must not disturb the last read value
                  if (!abort_now) wb_datrd <= bus_r_data;
                  abort  <= 1'b0;
                  wb_ack <= ~abort_now;
                  wb_err <= 1'b0;
                  state  <= abort_now ? IDLE : ACK;
               end
            end
            W_REQ: begin
               abort <= abort_now;
               if (bus_w_data_addr_ready) begin
                  bus_w_data_addr_valid <= 1'b0;
                  bus_w_resp_ready      <= 1'b1;
                  state                 <= W_RESP;
               end
            end
            W_RESP: begin
               abort <= abort_now;
               if (bus_w_resp_valid) begin
                  bus_w_resp_ready <= 1'b0;
                  abort            <= 1'b0;
                  wb_ack           <= ~abort_now;
                  wb_err           <= ~abort_now && (bus_w_resp != resp_width'(RESP_OK));
                  state            <= abort_now ? IDLE : ACK;
               end
            end
            ACK: begin
               wb_ack <= 1'b0;
               wb_err <= 1'b0;
               abort  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_bus_bridge.sv
// tb_wb_bus_bridge: directed WB transactions against a stall-configurable bus responder, scoreboard-checked
module tb_wb_bus_bridge;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] wb_adr = '0, wb_datwr = '0, wb_datrd;
   logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0, wb_ack, wb_err;
   logic [3:0]  wb_sel = '0;
   logic        bus_r_addr_valid, bus_r_addr_ready = 1'b0;
   logic [31:0] bus_r_addr;
   logic        bus_r_data_valid = 1'b0, bus_r_data_ready;
   logic [31:0] bus_r_data = '0;
   logic        bus_w_data_addr_valid, bus_w_data_addr_ready = 1'b0;
   logic [31:0] bus_w_data, bus_w_addr;
   logic [3:0]  bus_w_strobe;
   logic        bus_w_resp_valid = 1'b0, bus_w_resp_ready;
   logic [0:0]  bus_w_resp = '0;

   always #5 clock = ~clock;

   wb_bus_bridge dut (
      .clock(clock), .reset(reset),
      .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd), .wb_we(wb_we),
      .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
      .bus_r_addr_valid(bus_r_addr_valid), .bus_r_addr_ready(bus_r_addr_ready), .bus_r_addr(bus_r_addr),
      .bus_r_data_valid(bus_r_data_valid), .bus_r_data_ready(bus_r_data_ready), .bus_r_data(bus_r_data),
      .bus_w_data_addr_valid(bus_w_data_addr_valid), .bus_w_data_addr_ready(bus_w_data_addr_ready),
      .bus_w_data(bus_w_data), .bus_w_addr(bus_w_addr), .bus_w_strobe(bus_w_strobe),
      .bus_w_resp_valid(bus_w_resp_valid), .bus_w_resp_ready(bus_w_resp_ready), .bus_w_resp(bus_w_resp)
   );

   typedef struct {logic [31:0] dat; logic err;} ack_t;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] strobe;} req_t;
   ack_t ack_q[$];
   req_t req_q[$];
   int checks = 0, failures = 0;
   int r_stall = 0, w_stall = 0, resp_stall = 0, wv_cycles = 0;
   logic [31:0] rd_value = '0, last_rd = '0;
   logic        resp_value = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // bus-side responder: drives ready/valid at negedge after a configurable number of stall cycles
   initial begin
      int r_cnt, w_cnt, b_cnt;
      r_cnt = 0; w_cnt = 0; b_cnt = 0;
      forever begin
         @(negedge clock);
         if (reset || !bus_r_addr_valid) r_cnt = 0;
         bus_r_addr_ready = bus_r_addr_valid && r_cnt >= r_stall;
         if (bus_r_addr_valid && !bus_r_addr_ready) r_cnt++;
         bus_r_data_valid = bus_r_data_ready;
         bus_r_data = rd_value;
         if (reset || !bus_w_data_addr_valid) w_cnt = 0;
         bus_w_data_addr_ready = bus_w_data_addr_valid && w_cnt >= w_stall;
         if (bus_w_data_addr_valid && !bus_w_data_addr_ready) w_cnt++;
         if (bus_w_data_addr_valid) wv_cycles++;
         if (reset || !bus_w_resp_ready) b_cnt = 0;
         bus_w_resp_valid = bus_w_resp_ready && b_cnt >= resp_stall;
         if (bus_w_resp_ready && !bus_w_resp_valid) b_cnt++;
         bus_w_resp = resp_value;
      end
   end

   // monitor: pops expectations whenever the DUT acks or hands a request to the bus
   initial begin
      logic pr_v, pr_r, pw_v, pw_r;
      logic [31:0] pr_a, pw_a, pw_d;
      logic [3:0]  pw_s;
      ack_t a;
      req_t q;
      pr_v = 0; pr_r = 0; pw_v = 0; pw_r = 0; pr_a = '0; pw_a = '0; pw_d = '0; pw_s = '0;
      forever begin
         @(negedge clock);
         #2;
         if (reset) begin
            pr_v = 0; pw_v = 0;
         end else begin
            if (wb_ack) begin
               if (ack_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_ack: got ack=1 err=%b expected no ack", wb_err);
               end else begin
                  a = ack_q.pop_front();
                  check("ack_datrd", wb_datrd, a.dat);
                  check("ack_err", {31'b0, wb_err}, {31'b0, a.err});
               end
            end else if (wb_err) begin
               checks++; failures++;
               $display("FAIL err_without_ack: got err=1 expected 0");
            end
            if (bus_r_addr_valid && bus_r_addr_ready) begin
               if (req_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_read: got addr %h expected none", bus_r_addr);
               end else begin
                  q = req_q.pop_front();
                  check("read_kind", 32'(0), {31'b0, q.we});
                  check("read_addr", bus_r_addr, q.addr);
               end
            end
            if (bus_w_data_addr_valid && bus_w_data_addr_ready) begin
               if (req_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_write: got addr %h expected none", bus_w_addr);
               end else begin
                  q = req_q.pop_front();
                  check("write_kind", 32'(1), {31'b0, q.we});
                  check("write_addr", bus_w_addr, q.addr);
                  check("write_data", bus_w_data, q.data);
                  check("write_strobe", {28'b0, bus_w_strobe}, {28'b0, q.strobe});
               end
            end
            if (pr_v && !pr_r) begin
               check("r_valid_held", {31'b0, bus_r_addr_valid}, 32'd1);
               check("r_addr_stable", bus_r_addr, pr_a);
            end
            if (pw_v && !pw_r) begin
               check("w_valid_held", {31'b0, bus_w_data_addr_valid}, 32'd1);
               check("w_addr_stable", bus_w_addr, pw_a);
               check("w_data_stable", bus_w_data, pw_d);
               check("w_strobe_stable", {28'b0, bus_w_strobe}, {28'b0, pw_s});
            end
            pr_v = bus_r_addr_valid; pr_r = bus_r_addr_ready; pr_a = bus_r_addr;
            pw_v = bus_w_data_addr_valid; pw_r = bus_w_data_addr_ready;
            pw_a = bus_w_addr; pw_d = bus_w_data; pw_s = bus_w_strobe;
         end
      end
   end

   task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int exp_lat, input bit keep);
      int n;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_datwr = dat; wb_sel = sel;
      n = 0;
      do begin
         @(posedge clock);
         n++;
         @(negedge clock);
         #2;
      end while (!wb_ack && n < 50);
      check("ack_latency", n, exp_lat);
      if (!keep) begin
         wb_cyc = 1'b0; wb_stb = 1'b0;
      end
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] val, input int lat, input bit keep);
      rd_value = val;
      last_rd = val;
      req_q.push_back('{1'b0, adr, 32'h0, 4'h0});
      ack_q.push_back('{val, 1'b0});
      wb_req(1'b0, adr, 32'h0, 4'hF, lat, keep);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic resp, input int lat, input bit keep);
      resp_value = resp;
      req_q.push_back('{1'b1, adr, dat, sel});
      ack_q.push_back('{last_rd, resp});
      wb_req(1'b1, adr, dat, sel, lat, keep);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"}, {31'b0, wb_ack}, 32'd0);
      check({tag, "_err"}, {31'b0, wb_err}, 32'd0);
      check({tag, "_datrd"}, wb_datrd, 32'd0);
      check({tag, "_r_addr_valid"}, {31'b0, bus_r_addr_valid}, 32'd0);
      check({tag, "_r_addr"}, bus_r_addr, 32'd0);
      check({tag, "_r_data_ready"}, {31'b0, bus_r_data_ready}, 32'd0);
      check({tag, "_w_valid"}, {31'b0, bus_w_data_addr_valid}, 32'd0);
      check({tag, "_w_data"}, bus_w_data, 32'd0);
      check({tag, "_w_addr"}, bus_w_addr, 32'd0);
      check({tag, "_w_strobe"}, {28'b0, bus_w_strobe}, 32'd0);
      check({tag, "_resp_ready"}, {31'b0, bus_w_resp_ready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clock);
      #2;
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clock); #2;
      rd(32'h100, 32'hDEADBEEF, 3, 0);
      @(negedge clock); #2;
      w_stall = 2;
      wv_cycles = 0;
      wr(32'h200, 32'h12345678, 4'b0011, 1'b0, 5, 0);
      check("w_valid_cycles", wv_cycles, 3);
      w_stall = 0;
      @(negedge clock); #2;
      wr(32'h300, 32'hA5A5A5A5, 4'hF, 1'b1, 3, 0);
      @(negedge clock); #2;
      check("err_one_cycle_ack", {31'b0, wb_ack}, 32'd0);
      check("err_one_cycle_err", {31'b0, wb_err}, 32'd0);
      rd(32'h4, 32'hCAFEF00D, 3, 1);
      wr(32'h8, 32'h11223344, 4'hF, 1'b0, 4, 0);
      @(negedge clock); #2;
      check("b2b_datrd_kept", wb_datrd, 32'hCAFEF00D);
      r_stall = 4;
      rd_value = 32'h55555555;
      req_q.push_back('{1'b0, 32'h40, 32'h0, 4'h0});
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h40;
      @(posedge clock);
      @(negedge clock); #2;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      repeat (12) @(negedge clock);
      #2;
      check("abort_bus_drained", req_q.size(), 0);
      check("abort_no_ack_pending", ack_q.size(), 0);
      check("abort_r_idle", {31'b0, bus_r_addr_valid | bus_r_data_ready}, 32'd0);
      r_stall = 0;
      resp_stall = 5;
      req_q.push_back('{1'b1, 32'h80, 32'hFEEDFACE, 4'b1100});
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h80; wb_datwr = 32'hFEEDFACE; wb_sel = 4'b1100;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clock); #2;
      check_all_zero("midreset");
      reset = 1'b0;
      resp_stall = 0;
      last_rd = 32'h0;
      @(negedge clock); #2;
      rd(32'h500, 32'h0BADF00D, 3, 0);
      repeat (3) @(negedge clock);
      #2;
      check("final_ack_q_empty", ack_q.size(), 0);
      check("final_req_q_empty", req_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
